// File: rtl/cc_sar_pkg.sv
// Shared definitions for the successive-approximation search engine:
// FSM state encoding and the comparator-flag sanity helper.
package cc_sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIAL = 2'd1,
    ST_DONE  = 2'd2
  } sar_state_e;

  // A consistent comparator asserts exactly one of {gt, lt, eq}.
  function automatic logic flags_onehot(input logic [2:0] flags);
    return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  endfunction

endpackage

// File: rtl/cc_sar_search.sv
// Successive-approximation search: drives a trial value into an external
// magnitude comparator and narrows one bit per clock from its flags.
module cc_sar_search
  import cc_sar_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = 8,
  localparam int IW = (NUMBER_DATAWIDTH > 1) ? $clog2(NUMBER_DATAWIDTH) : 1,
  localparam int CW = $clog2(NUMBER_DATAWIDTH + 1)
) (
  input  logic                        CC_SARSEARCH_CLOCK_50,
  input  logic                        CC_SARSEARCH_RESET_InLow,
  input  logic                        CC_SARSEARCH_start_In,
  input  logic                        CC_SARSEARCH_greaterthan_In,
  input  logic                        CC_SARSEARCH_lessthan_In,
  input  logic                        CC_SARSEARCH_equal_In,
  output logic [NUMBER_DATAWIDTH-1:0] CC_SARSEARCH_trial_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] CC_SARSEARCH_result_OutBUS,
  output logic                        CC_SARSEARCH_busy_Out,
  output logic                        CC_SARSEARCH_done_Out,
  output logic                        CC_SARSEARCH_error_Out,
  output logic [CW-1:0]               CC_SARSEARCH_count_OutBUS
);

  localparam int N = NUMBER_DATAWIDTH;
  localparam logic [IW-1:0] IDX_TOP  = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  MSB_ONE  = {1'b1, {(N-1){1'b0}}};

  sar_state_e    state_q, state_d;
  logic [N-1:0]  trial_q, trial_d;
  logic [N-1:0]  result_q, result_d;
  logic [IW-1:0] index_q, index_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  trial_upd_s;
  logic [2:0]    flags_s;

  assign flags_s = {CC_SARSEARCH_greaterthan_In, CC_SARSEARCH_lessthan_In,
                    CC_SARSEARCH_equal_In};

  // State and datapath registers; busy/done are registered from next state.
  always_ff @(posedge CC_SARSEARCH_CLOCK_50 or negedge CC_SARSEARCH_RESET_InLow) begin
    if (!CC_SARSEARCH_RESET_InLow) begin
      state_q  <= ST_IDLE;
      trial_q  <= {N{1'b0}};
      result_q <= {N{1'b0}};
      index_q  <= IDX_TOP;
      count_q  <= {CW{1'b0}};
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      index_q  <= index_d;
      count_q  <= count_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and one-decision-per-clock search step.
  always_comb begin
    state_d     = state_q;
    trial_d     = trial_q;
    result_d    = result_q;
    index_d     = index_q;
    count_d     = count_q;
    error_d     = error_q;
    // gt keeps the tested bit, lt clears it; bit was set when it became the trial bit
    trial_upd_s = trial_q;
    trial_upd_s[index_q] = trial_q[index_q] & ~CC_SARSEARCH_lessthan_In;

    case (state_q)
      ST_IDLE: begin
        if (CC_SARSEARCH_start_In) begin
          trial_d = MSB_ONE;
          index_d = IDX_TOP;
          count_d = {CW{1'b0}};
          error_d = 1'b0;
          state_d = ST_TRIAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIAL: begin
        count_d = count_q + CNT_ONE;
        if (!flags_onehot(flags_s)) begin
          error_d  = 1'b1;
          result_d = {N{1'b0}};
          state_d  = ST_DONE;
        end else if (CC_SARSEARCH_equal_In) begin
          result_d = trial_q;
          state_d  = ST_DONE;
        end else if (index_q == IDX_ZERO) begin
          trial_d  = trial_upd_s;
          result_d = trial_upd_s;
          state_d  = ST_DONE;
        end else begin
          trial_d  = trial_upd_s;
          trial_d[index_q - IDX_ONE] = 1'b1;
          index_d  = index_q - IDX_ONE;
          state_d  = ST_TRIAL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_TRIAL) || (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  assign CC_SARSEARCH_trial_OutBUS  = trial_q;
  assign CC_SARSEARCH_result_OutBUS = result_q;
  assign CC_SARSEARCH_busy_Out      = busy_q;
  assign CC_SARSEARCH_done_Out      = done_q;
  assign CC_SARSEARCH_error_Out     = error_q;
  assign CC_SARSEARCH_count_OutBUS  = count_q;

endmodule

// File: tb/tb_cc_sar_search.sv
// Self-checking bench: cc_sar_search wrapped with a behavioural comparator
// whose target is chosen by the bench; flags can be overridden to inject faults.
module tb_cc_sar_search;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          gt, lt, eq;
  logic [N-1:0]  trial, result;
  logic          busy, done, err;
  logic [CW-1:0] count;
  logic [N-1:0]  target = 8'd0;
  logic          force_en = 1'b0;
  logic [2:0]    force_val = 3'b000;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  // Comparator: target on dataA, DUT trial on dataB.
  always_comb begin
    if (force_en) begin
      {gt, lt, eq} = force_val;
    end else begin
      gt = (target > trial);
      lt = (target < trial);
      eq = (target == trial);
    end
  end

  cc_sar_search #(.NUMBER_DATAWIDTH(N)) dut (
    .CC_SARSEARCH_CLOCK_50      (clk),
    .CC_SARSEARCH_RESET_InLow   (rst_n),
    .CC_SARSEARCH_start_In      (start),
    .CC_SARSEARCH_greaterthan_In(gt),
    .CC_SARSEARCH_lessthan_In   (lt),
    .CC_SARSEARCH_equal_In      (eq),
    .CC_SARSEARCH_trial_OutBUS  (trial),
    .CC_SARSEARCH_result_OutBUS (result),
    .CC_SARSEARCH_busy_Out      (busy),
    .CC_SARSEARCH_done_Out      (done),
    .CC_SARSEARCH_error_Out     (err),
    .CC_SARSEARCH_count_OutBUS  (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Binary search ends on equality at the target's lowest set bit; target 0 needs all N.
  function automatic int exp_k(input logic [N-1:0] t);
    if (t == 8'd0) return N;
    for (int b = 0; b < N; b++) if (t[b]) return N - b;
    return N;
  endfunction

  // Trial at step s: target's already-resolved upper bits plus the bit under test.
  function automatic logic [N-1:0] exp_trial(input logic [N-1:0] t, input int s);
    int b;
    logic [N-1:0] ones;
    logic [N-1:0] hi;
    b    = N - s;
    ones = 8'hFF;
    hi   = t & (ones << (b + 1));
    return hi | (N'(1) << b);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_trial"}, trial, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, err, 0);
    check({tag, "_count"}, count, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("idle_before_start", busy, 0);
  endtask

  task automatic run_search(input logic [N-1:0] tgt, input int fstep,
                            input logic [2:0] fval, input bit noise);
    int cycles, step, k;
    logic [N-1:0] exp_res;
    bit exp_err;
    wait_idle();
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    cycles  = 1;
    step    = 1;
    exp_err = (fstep != 0);
    k       = exp_err ? fstep : exp_k(tgt);
    exp_res = exp_err ? 8'd0 : tgt;
    while (!done && cycles < 20) begin
      check("trial_step", trial, exp_trial(tgt, step));
      check("busy_in_trial", busy, 1);
      if (step == fstep) begin
        force_en  = 1'b1;
        force_val = fval;
      end
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cycles++;
      step++;
    end
    start    = 1'b0;
    force_en = 1'b0;
    check("done_seen", done, 1);
    check("latency", cycles, k + 1);
    check("result", result, exp_res);
    check("count", count, k);
    check("error", err, exp_err);
    check("busy_at_done", busy, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("result_hold", result, exp_res);
    check("count_hold", count, k);
  endtask

  initial begin
    int d1, d2, n;
    logic [N-1:0] rt;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_search(8'd0,   0, 3'b000, 1'b0);
    run_search(8'd128, 0, 3'b000, 1'b0);
    run_search(8'd255, 0, 3'b000, 1'b0);

    run_search(8'd0,  2, 3'b000, 1'b0);
    run_search(8'd0,  1, 3'b011, 1'b0);
    run_search(8'd77, 0, 3'b000, 1'b0);

    // start held high: back-to-back searches every k+2 clocks
    wait_idle();
    @(negedge clk);
    target = 8'd128;
    start  = 1'b1;
    d1 = 0; d2 = 0; n = 0;
    while (d2 == 0 && n < 20) begin
      @(posedge clk); #1; n++;
      if (done) begin
        if (d1 == 0) d1 = n;
        else d2 = n;
      end
    end
    start = 1'b0;
    check("held_first_done", d1, 2);
    check("held_period", d2 - d1, 3);

    // reset in the middle of a search
    wait_idle();
    @(negedge clk);
    target = 8'd0;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    repeat (2) begin @(posedge clk); #1; check("reset_no_done", done, 0); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
    end

    for (int t = 0; t < 256; t++) run_search(N'(t), 0, 3'b000, 1'b1);

    for (int i = 0; i < 16; i++) begin
      rt = N'($urandom_range(0, 255));
      run_search(rt, 0, 3'b000, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
